// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: shared widths and the {valid, wn, d} write-request bundle
package rf_wport_arbiter_pkg;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] wn;
        logic [DATA_W-1:0]    d;
    } wreq_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bits for outstanding MDU destinations plus RAW/WAW hazard detect
//   clk, clrn          clock, async active-high reset
//   set_en, set_idx    mark a register busy (ignored for index 0)
//   clr_en, clr_idx    release a register once its result is written
//   rna, rnb, we, wn   decode sources and destination under test
//   busy               scoreboard vector, bit 0 always 0
//   hazard             RAW on either source or WAW on the destination
module rf_scoreboard
    import rf_wport_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rna,
    input  logic [REG_IDX_W-1:0] rnb,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wn,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 hazard
);
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    assign set_mask = NUM_REGS'(set_en && set_idx != '0) << set_idx;
    assign clr_mask = NUM_REGS'(clr_en) << clr_idx;

    // set is applied after clear so a same-cycle set wins
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) busy <= '0;
        else      busy <= (busy & ~clr_mask) | set_mask;
    end

    // bit 0 is never set, so the WAW term needs no explicit wn != 0 guard
    assign hazard = (busy[rna] && rna != '0) || (busy[rnb] && rnb != '0) || (we && busy[wn]);
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the regfile write port between WB and the MDU with a one-entry hold
//   clk, clrn                      clock, async active-high reset
//   wb_we, wb_wn, wb_d             pipeline writeback request (always wins the port)
//   mdu_valid, mdu_wn, mdu_d       MDU result, held stable by the MDU until mdu_ready
//   mdu_ready                      holding register empty
//   dec_rna, dec_rnb, dec_we,
//   dec_wn, dec_mdu                decode operands and MDU issue
//   stall                          freeze fetch/decode and insert a bubble
//   rf_we, rf_wn, rf_d             regfile write port
//   busy                           scoreboard of outstanding MDU destinations
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_wn,
    input  logic [DATA_W-1:0]    wb_d,
    input  logic                 mdu_valid,
    input  logic [REG_IDX_W-1:0] mdu_wn,
    input  logic [DATA_W-1:0]    mdu_d,
    output logic                 mdu_ready,
    input  logic [REG_IDX_W-1:0] dec_rna,
    input  logic [REG_IDX_W-1:0] dec_rnb,
    input  logic                 dec_we,
    input  logic [REG_IDX_W-1:0] dec_wn,
    input  logic                 dec_mdu,
    output logic                 stall,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_wn,
    output logic [DATA_W-1:0]    rf_d,
    output logic [NUM_REGS-1:0]  busy
);
    wreq_t            wb, mdu, hold;
    logic [CNT_W-1:0] starve_cnt;
    logic             wb_act, drain, capture, starved, hazard;

    assign wb  = '{valid: wb_we, wn: wb_wn, d: wb_d};
    assign mdu = '{valid: mdu_valid, wn: mdu_wn, d: mdu_d};

    // gated by reset so the port stays quiet while clrn is held
    assign wb_act    = wb.valid && wb.wn != '0 && !clrn;
    assign drain     = hold.valid && !wb_act;
    assign mdu_ready = !hold.valid;
    assign capture   = mdu.valid && mdu_ready;
    assign starved   = starve_cnt == CNT_W'(STARVE_LIMIT);

    assign rf_we = wb_act || hold.valid;
    assign rf_wn = wb_act ? wb.wn : hold.valid ? hold.wn : '0;
    assign rf_d  = wb_act ? wb.d : hold.valid ? hold.d : '0;

    // capture needs an empty hold and drain a full one, so they never coincide
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            hold       <= '0;
            starve_cnt <= '0;
        end else begin
            if (capture)    hold       <= mdu;
            else if (drain) hold.valid <= 1'b0;
            if (drain)                             starve_cnt <= '0;
            else if (hold.valid && wb_act && !starved) starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // hold stays full next cycle exactly when it holds now and is not drained
    assign stall = hazard || (dec_mdu && hold.valid && !drain) || starved;

    rf_scoreboard u_sb (
        .clk     (clk),
        .clrn    (clrn),
        .set_en  (dec_we && dec_mdu && !stall),
        .set_idx (dec_wn),
        .clr_en  (drain),
        .clr_idx (hold.wn),
        .rna     (dec_rna),
        .rnb     (dec_rnb),
        .we      (dec_we),
        .wn      (dec_wn),
        .busy    (busy),
        .hazard  (hazard)
    );
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed scenarios checked against a behavioural port/scoreboard model
module tb_rf_wport_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0, clrn = 1'b1;
    logic        wb_we, mdu_valid, dec_we, dec_mdu;
    logic [4:0]  wb_wn, mdu_wn, dec_rna, dec_rnb, dec_wn;
    logic [31:0] wb_d, mdu_d;
    logic        mdu_ready, stall, rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d, busy;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(3)) dut (
        .clk(clk), .clrn(clrn),
        .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
        .mdu_valid(mdu_valid), .mdu_wn(mdu_wn), .mdu_d(mdu_d), .mdu_ready(mdu_ready),
        .dec_rna(dec_rna), .dec_rnb(dec_rnb), .dec_we(dec_we), .dec_wn(dec_wn), .dec_mdu(dec_mdu),
        .stall(stall), .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d), .busy(busy)
    );

    // model state: one pending MDU result, the set of outstanding destinations, blocked-cycle count
    logic [31:0] m_busy, n_busy;
    logic        m_hv;
    logic [4:0]  m_hwn;
    logic [31:0] m_hd;
    int          m_starve, n_starve;
    logic        wb_ok, written, e_stall, e_rf_we;
    logic [4:0]  e_rf_wn;
    logic [31:0] e_rf_d;

    always_comb begin
        wb_ok   = wb_we && wb_wn != 0 && !clrn;
        written = m_hv && !wb_ok;
        e_rf_we = wb_ok || m_hv;
        e_rf_wn = wb_ok ? wb_wn : (m_hv ? m_hwn : 5'd0);
        e_rf_d  = wb_ok ? wb_d : (m_hv ? m_hd : 32'd0);
        e_stall = !clrn && ((dec_rna != 0 && m_busy[dec_rna]) || (dec_rnb != 0 && m_busy[dec_rnb])
                  || (dec_we && dec_wn != 0 && m_busy[dec_wn]) || (dec_mdu && m_hv && !written)
                  || m_starve >= LIM);
        n_busy = m_busy;
        if (written) n_busy[m_hwn] = 1'b0;
        if (dec_we && dec_mdu && dec_wn != 0 && !e_stall) n_busy[dec_wn] = 1'b1;
        n_starve = written ? 0 : (m_hv && wb_ok) ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : m_starve;
    end

    always @(posedge clk or posedge clrn) begin
        if (clrn) begin
            m_busy <= 0; m_hv <= 0; m_hwn <= 0; m_hd <= 0; m_starve <= 0;
        end else begin
            m_busy   <= n_busy;
            m_starve <= n_starve;
            if (written) m_hv <= 1'b0;
            if (!m_hv && mdu_valid) begin
                m_hv <= 1'b1; m_hwn <= mdu_wn; m_hd <= mdu_d;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("mdl_ready", 32'(mdu_ready), 32'(!m_hv));
        check("mdl_stall", 32'(stall), 32'(e_stall));
        check("mdl_rf_we", 32'(rf_we), 32'(e_rf_we));
        check("mdl_rf_wn", 32'(rf_wn), 32'(e_rf_wn));
        check("mdl_rf_d", rf_d, e_rf_d);
        check("mdl_busy", busy, m_busy);
    end

    task automatic idle();
        wb_we = 0; wb_wn = 0; wb_d = 0; mdu_valid = 0; mdu_wn = 0; mdu_d = 0;
        dec_rna = 0; dec_rnb = 0; dec_we = 0; dec_wn = 0; dec_mdu = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [4:0] wn);
        idle(); dec_we = 1; dec_mdu = 1; dec_wn = wn;
        tick(); idle();
    endtask

    initial begin
        idle();
        wb_we = 1; wb_wn = 3; wb_d = 32'h5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_ready", 32'(mdu_ready), 1);
        check("rst_busy", busy, 0);
        check("rst_stall", 32'(stall), 0);
        tick(); clrn = 0; idle();

        // basic MDU result, written one cycle after capture
        issue(5);
        mdu_valid = 1; mdu_wn = 5; mdu_d = 32'h1234;
        @(negedge clk);
        check("s1_busy5", 32'(busy[5]), 1);
        check("s1_ready", 32'(mdu_ready), 1);
        tick(); idle();
        @(negedge clk);
        check("s1_ready_drop", 32'(mdu_ready), 0);
        check("s1_rf_we", 32'(rf_we), 1);
        check("s1_rf_wn", 32'(rf_wn), 5);
        check("s1_rf_d", rf_d, 32'h1234);
        tick();
        @(negedge clk);
        check("s1_busy_clr", busy, 0);
        check("s1_rf_idle", 32'(rf_we), 0);

        // RAW on r7 until the cycle after its write
        issue(7);
        dec_rna = 7; mdu_valid = 1; mdu_wn = 7; mdu_d = 32'h77;
        @(negedge clk);
        check("s2_raw", 32'(stall), 1);
        tick(); mdu_valid = 0;
        @(negedge clk);
        check("s2_raw_wr", 32'(stall), 1);
        check("s2_wn", 32'(rf_wn), 7);
        tick();
        @(negedge clk);
        check("s2_release", 32'(stall), 0);
        issue(0);
        @(negedge clk);
        check("s2_wn0_noset", busy, 0);

        // starvation of a held r3 by six WB writes to r9
        issue(3);
        mdu_valid = 1; mdu_wn = 3; mdu_d = 32'h3333;
        tick(); idle();
        for (int k = 1; k <= 6; k++) begin
            idle(); wb_we = 1; wb_wn = 9; wb_d = 32'(k);
            if (k == 2) begin dec_we = 1; dec_mdu = 1; dec_wn = 20; end
            @(negedge clk);
            check("s3_wb_wn", 32'(rf_wn), 9);
            if (k == 2) check("s3_struct", 32'(stall), 1);
            if (k == 4) check("s3_nostarve", 32'(stall), 0);
            if (k == 5) check("s3_starve", 32'(stall), 1);
            tick();
        end
        idle();
        @(negedge clk);
        check("s3_drain_wn", 32'(rf_wn), 3);
        check("s3_drain_d", rf_d, 32'h3333);
        tick();
        @(negedge clk);
        check("s3_unstall", 32'(stall), 0);
        check("s3_busy", busy, 0);

        // WB to r0 never blocks the held entry
        issue(10);
        mdu_valid = 1; mdu_wn = 10; mdu_d = 32'hA0;
        tick(); idle();
        wb_we = 1; wb_wn = 0; wb_d = 32'hDEAD;
        @(negedge clk);
        check("s4_we", 32'(rf_we), 1);
        check("s4_wn", 32'(rf_wn), 10);
        check("s4_d", rf_d, 32'hA0);
        tick(); idle();
        @(negedge clk);
        check("s4_busy", busy, 0);

        // WAW on r7: no re-set until the old entry is cleared
        issue(7);
        dec_we = 1; dec_mdu = 1; dec_wn = 7;
        @(negedge clk);
        check("s5_waw", 32'(stall), 1);
        tick(); mdu_valid = 1; mdu_wn = 7; mdu_d = 32'h70;
        @(negedge clk);
        check("s5_waw_cap", 32'(stall), 1);
        tick(); mdu_valid = 0;
        @(negedge clk);
        check("s5_waw_wr", 32'(stall), 1);
        check("s5_wr_wn", 32'(rf_wn), 7);
        tick();
        @(negedge clk);
        check("s5_cleared", 32'(busy[7]), 0);
        check("s5_free", 32'(stall), 0);
        tick(); idle();
        @(negedge clk);
        check("s5_reset7", 32'(busy[7]), 1);

        // asynchronous reset while r12 is held behind WB
        issue(12);
        mdu_valid = 1; mdu_wn = 12; mdu_d = 32'hC0; wb_we = 1; wb_wn = 9; wb_d = 32'h99;
        tick(); mdu_valid = 0;
        @(negedge clk);
        check("s6_held", 32'(mdu_ready), 0);
        check("s6_busy12", 32'(busy[12]), 1);
        #2 clrn = 1;
        #1;
        check("s6_async_busy", busy, 0);
        check("s6_async_ready", 32'(mdu_ready), 1);
        check("s6_async_we", 32'(rf_we), 0);
        @(posedge clk); #1 clrn = 0; idle();
        @(negedge clk);
        check("s6_no_write", 32'(rf_we), 0);
        tick();
        @(negedge clk);
        check("s6_no_write2", 32'(rf_we), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order pipeline writeback and a long-latency multiply/divide unit (MDU).
- Keeps a per-register busy scoreboard for outstanding MDU destinations and raises a decode stall on RAW/WAW hazards against them.
- Sits between the WB stage, the MDU and the regfile write port (we, wn, d), beside the hazard/forwarding logic.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles a held MDU result may be blocked by pipeline writeback before a forced bubble is requested.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising-edge.
- clrn  in  1  reset, asynchronous, active-high.
- wb_we  in  1  pipeline writeback request.
- wb_wn  in  5  pipeline writeback destination.
- wb_d  in  32  pipeline writeback data.
- mdu_valid  in  1  MDU result valid.
- mdu_wn  in  5  MDU result destination.
- mdu_d  in  32  MDU result data.
- mdu_ready  out  1  arbiter can accept an MDU result.
- dec_rna  in  5  decode source A.
- dec_rnb  in  5  decode source B.
- dec_we  in  1  decode instruction writes a register.
- dec_wn  in  5  decode destination.
- dec_mdu  in  1  decode instruction issues to the MDU this cycle (qualified by dec_we).
- stall  out  1  freeze fetch/decode and insert a bubble.
- rf_we  out  1  regfile write enable.
- rf_wn  out  5  regfile write index.
- rf_d  out  32  regfile write data.
- busy  out  32  scoreboard; bit 0 always 0.

Behaviour:
- Reset (clrn=1, asynchronous): busy=0, hold_v=0, hold_wn=0, hold_d=0, starve_cnt=0.
  - Outputs during reset: mdu_ready=1, stall=0, rf_we=0, rf_wn=0, rf_d=0.
- Reset mid-operation discards any held result and all busy bits.
- Holding register: one entry (hold_v, hold_wn, hold_d).
  - mdu_ready = ~hold_v, combinational.
  - Captured at posedge when mdu_valid & mdu_ready.
  - mdu_valid with mdu_ready=0: the MDU holds its result stable and retries.
- Write-port grant, combinational, one writer per cycle:
  - wb_act = wb_we & (wb_wn != 0).
  - Pipeline wins: if wb_act, then rf_we=1, rf_wn=wb_wn, rf_d=wb_d.
  - Else if hold_v: rf_we=1 from the holding register, and hold_v clears at posedge.
  - Else rf_we=0, rf_wn=0, rf_d=0.
- Latency:
  - Accepted MDU result is written no earlier than the cycle after capture; there is no same-cycle pass-through.
  - Minimum MDU result-to-regfile latency is 1 cycle.
  - Back-to-back MDU results: capture and drain can overlap only across cycles, giving throughput of 1 result per 2 cycles.
- Starvation control:
  - starve_cnt increments each cycle hold_v & wb_act, saturating at STARVE_LIMIT.
  - It resets to 0 when the held entry is written.
  - stall is forced while starve_cnt == STARVE_LIMIT; the bubble reaches WB and frees the port.
- Scoreboard:
  - Set: at posedge, busy[dec_wn] <= 1 when dec_we & dec_mdu & (dec_wn != 0) & ~stall.
  - Clear: busy[hold_wn] <= 0 when the held entry is written to the regfile.
  - Same-cycle set and clear of the same index: set wins. This is unreachable by construction, because the WAW stall blocks it.
  - dec_wn = 0 never sets a bit.
- stall is the OR of:
  - busy[dec_rna] with dec_rna != 0;
  - busy[dec_rnb] with dec_rnb != 0;
  - dec_we & busy[dec_wn] (WAW);
  - dec_mdu & hold_v & ~mdu_ready_next, i.e. hold_v remains set next cycle (structural);
  - starvation.
- Consumers of a busy register stall through the write cycle.
  - Release is the cycle after rf_we for that index, when the regfile holds the new value.
  - No bypass from hold_d.
- Pipeline writes with wn=0 are ignored and never block the held entry.

Decomposition:
- Shared package constants:
  - REG_IDX_W=5, NUM_REGS=32, DATA_W=32;
  - a typedef for the {valid, wn, d} write-request bundle, reused by the writeback stage and the MDU.
- One natural sub-module: rf_scoreboard.
  - Contains the busy vector with set/clear ports and the combinational hazard compare producing the RAW/WAW stall terms.
- The arbitration and holding register stay in the top.

Test Plan:
- Reset, then MDU result wn=5, d=0x1234 with wb_we=0 → mdu_ready drops next cycle; rf_we=1, rf_wn=5, rf_d=0x1234 one cycle after capture; busy[5] clears.
- Issue MDU to r7; decode reads rna=7 → stall=1 until the cycle after r7 is written; rnb=0 never stalls even if busy bit 0 is forced.
- Hold an MDU result for r3 while wb_we=1 with wb_wn=9 for 6 consecutive cycles → pipeline writes granted each cycle; stall asserts after STARVE_LIMIT=4 blocked cycles; the held entry writes in the first bubble cycle; starve_cnt returns to 0.
- wb_we=1 with wb_wn=0 while hold_v=1 → held entry is written that cycle; no register-0 write.
- Decode dec_we=1 with dec_wn=7 while busy[7]=1 → WAW stall; the busy bit is not re-set until after the clear.
- Assert clrn mid-hold with busy[12]=1 → busy=0, mdu_ready=1, rf_we=0 immediately, asynchronously; no write of the discarded data after release.
